csa64_op_sequencer: RTL and testbench
=====================================

Name: csa64_op_sequencer

Overview:
- Operand-issue and result-capture stage wrapped around the 64-bit conditional sum adder.
- Accepts add/sub requests on a valid/ready handshake and holds operands stable to the adder while it computes.
- Drives the adder's start, waits for its complete, then registers sum, carry and correct signed flags.
- Presents the result on a second valid/ready handshake and detects adders that never complete (timeout).

Parameters:
WIDTH, 64, operand/sum width; must match the adder.
TIMEOUT, 32, max cycles in WAIT before aborting with err; legal range 2..255.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  sequencer can accept a request.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sub  input  1  1 = A-B, 0 = A+B.
in_cin  input  1  carry-in for add; ignored for sub.
ope1  output  WIDTH  registered A to adder.
ope2  output  WIDTH  registered B to adder.
add_sub  output  1  registered in_sub to adder.
Cin  output  1  registered carry-in to adder (in_cin for add, 0 for sub).
start  output  1  adder start.
sum  input  WIDTH  adder sum.
cout  input  1  adder carry-out.
complete  input  1  adder done.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  captured sum.
out_cout  output  1  captured carry/borrow-out.
out_ovf  output  1  signed overflow.
out_zero  output  1  out_sum == 0.
out_err  output  1  timeout abort; data fields are 0 when set.

Behaviour:
- Reset (async, immediate): state IDLE. in_ready=1. All other outputs 0: start, out_valid, ope1, ope2, add_sub, Cin, out_*, and the timer.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE: in_ready=1.
  - On in_valid: latch in_a→ope1, in_b→ope2, in_sub→add_sub, Cin=(in_sub?0:in_cin), and the operand sign bits.
  - Go to LAUNCH.
- LAUNCH (1 cycle): start=1, in_ready=0, timer cleared. complete is ignored here, so a stale complete from the prior op is not sampled. Go to WAIT.
- WAIT: start held 1; timer increments each cycle.
  - On complete=1: capture result into out_* registers and go to DONE.
    - out_sum=sum, out_cout=cout, out_zero=(sum==0).
    - out_ovf for add = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]).
    - out_ovf for sub = (a[W-1]!=b[W-1]) & (sum[W-1]!=a[W-1]).
  - Else if timer reaches TIMEOUT-1: out_err=1, data fields 0, go to DONE.
  - complete has priority over timeout in the same cycle.
- DONE: start=0, out_valid=1. Outputs held stable until out_ready.
  - On out_valid & out_ready: out_valid→0 next cycle, out_err cleared, go to IDLE.
- Timing:
  - Latency from request accept to out_valid = 2 + N cycles, where N = cycles from WAIT entry to complete.
  - Throughput is one op per ≥4 cycles; no overlap of operations.
- ope1/ope2/add_sub/Cin change only in IDLE on accept. They are stable through LAUNCH, WAIT and DONE.
- in_valid while busy is not accepted (in_ready=0); the request must be held by the upstream.
- Reset mid-operation: abort immediately. No result is emitted and the next op starts clean.

Test Plan:
1. Reset asserted mid-WAIT with start=1 → start, out_valid, in_ready=0/0/1 in the same cycle, asynchronously.
2. Add a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0, complete 3 cycles into WAIT → out_sum=64'h8000_0000_0000_0000, out_ovf=1, out_cout=0, out_zero=0. out_valid rises exactly 5 cycles after accept.
3. Sub a=5, b=5 (adder returns 0, cout=1) → out_zero=1, out_ovf=0, out_cout=1; ope2=5, add_sub=1, Cin=0 while busy.
4. Sub a=64'h8000_0000_0000_0000, b=1 → out_ovf=1. Add a=b=64'hFFFF_FFFF_FFFF_FFFF → out_ovf=0, out_cout=1.
5. complete tied high before request → ignored in LAUNCH; capture occurs on first WAIT cycle. complete never asserted → out_err=1 after TIMEOUT WAIT cycles, with out_sum=0.
6. out_ready held low 10 cycles in DONE → out_* stable, in_ready=0, a new in_valid is not accepted. Release → IDLE next cycle, then the second op is accepted.

Source files
------------

// File: rtl/csa64_op_sequencer.sv
// ---------------------------------------------------------------------------
// csa64_op_sequencer
//
// Operand-issue and result-capture stage wrapped around a 64-bit conditional
// sum adder. A request is accepted on an in_valid/in_ready handshake. Its
// operands are registered and held stable on ope1/ope2/add_sub/Cin. start is
// raised until the adder signals complete. Sum, carry-out, signed overflow
// and zero are then captured and presented on an out_valid/out_ready
// handshake. An adder that never completes is aborted after TIMEOUT cycles
// in WAIT, and the result is reported with out_err set and zeroed data.
//
// Operation sequence:
//   IDLE --accept--> LAUNCH --1 cycle--> WAIT --complete|timeout--> DONE
//   DONE --out_ready--> IDLE
//
// Control outputs in_ready, start and out_valid are registered from the
// next state. This keeps them glitch-free towards the adder and the
// consumer. They still reach their reset values asynchronously.
// ---------------------------------------------------------------------------
module csa64_op_sequencer #(
    parameter int WIDTH   = 64,  // operand/sum width, must match the adder
    parameter int TIMEOUT = 32   // max cycles spent in WAIT, legal 2..255
) (
    input  logic             clock,
    input  logic             reset,

    // request side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,

    // adder side
    output logic [WIDTH-1:0] ope1,
    output logic [WIDTH-1:0] ope2,
    output logic             add_sub,
    output logic             Cin,
    output logic             start,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             complete,

    // result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_err
);

    // -----------------------------------------------------------------------
    // State encoding and constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // The timer counts WAIT cycles starting from 0. The last cycle that is
    // still allowed to see complete is the one where timer == TIMEOUT-1.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [7:0] timer;

    logic       accept;       // request handshake fires this cycle
    logic       release_res;  // result handshake fires this cycle
    logic       capture;      // adder result is sampled this cycle
    logic       expire;       // WAIT budget is exhausted without complete

    // The sign bits of the operands used for overflow are the MSBs of the
    // held operand registers. Those registers only change on accept, so they
    // are always the signs of the operation in flight.
    logic       a_sign;
    logic       b_sign;
    logic       s_sign;
    logic       ovf_now;

    assign accept      = (state == S_IDLE) && in_valid;
    assign release_res = (state == S_DONE) && out_ready;
    // complete has priority over the timeout when both occur in one cycle.
    assign capture     = (state == S_WAIT) && complete;
    assign expire      = (state == S_WAIT) && !complete && (timer == TIMER_LAST);

    assign a_sign = ope1[WIDTH-1];
    assign b_sign = ope2[WIDTH-1];
    assign s_sign = sum[WIDTH-1];

    // Overflow: an add overflows when two same-sign operands give a result
    // of the other sign. A subtract overflows when two operands of opposite
    // sign give a result whose sign differs from A.
    assign ovf_now = add_sub ? ((a_sign != b_sign) && (s_sign != a_sign))
                             : ((a_sign == b_sign) && (s_sign != a_sign));

    // Next-state decode for the operation sequence
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first,
        // so no path can leave it unassigned and infer a latch.
        next_state = state;
        case (state)
            S_IDLE:   if (in_valid)             next_state = S_LAUNCH;
            S_LAUNCH:                           next_state = S_WAIT;
            S_WAIT:   if (capture || expire)    next_state = S_DONE;
            S_DONE:   if (out_ready)            next_state = S_IDLE;
            default:                            next_state = S_IDLE;
        endcase
    end

    // State register together with the registered handshake and start outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            start     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples values from before this edge.
            state     <= next_state;
            in_ready  <= (next_state == S_IDLE);
            start     <= (next_state == S_LAUNCH) || (next_state == S_WAIT);
            out_valid <= (next_state == S_DONE);
        end
    end

    // Operand registers: loaded only on accept, then held for the adder
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ope1    <= '0;
            ope2    <= '0;
            add_sub <= 1'b0;
            Cin     <= 1'b0;
        end else if (accept) begin
            ope1    <= in_a;
            ope2    <= in_b;
            add_sub <= in_sub;
            // A subtract gets its +1 inside the adder, so the carry-in is
            // forced to 0 and in_cin is ignored.
            Cin     <= in_sub ? 1'b0 : in_cin;
        end
    end

    // WAIT-cycle timer: cleared in LAUNCH, incremented each cycle in WAIT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == S_LAUNCH) begin
            timer <= '0;
        end else if (state == S_WAIT) begin
            timer <= timer + 8'd1;
        end
    end

    // Result capture on complete, zeroed abort on timeout, error clear on release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_err  <= 1'b0;
        end else if (capture) begin
            out_sum  <= sum;
            out_cout <= cout;
            out_ovf  <= ovf_now;
            out_zero <= (sum == '0);
            out_err  <= 1'b0;
        end else if (expire) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_err  <= 1'b1;
        end else if (release_res) begin
            out_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csa64_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_csa64_op_sequencer
//
// Drives add/sub requests and plays the adder: it raises complete a chosen
// number of WAIT cycles after start. When complete is high it returns the
// arithmetic result of the operands the DUT presents. Expected results come
// from a 65/66-bit arithmetic reference applied to the requested operands.
// ---------------------------------------------------------------------------
module tb_csa64_op_sequencer;

    localparam int WIDTH   = 64;
    localparam int TIMEOUT = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic [WIDTH-1:0] ope1;
    logic [WIDTH-1:0] ope2;
    logic             add_sub;
    logic             Cin;
    logic             start;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             complete;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_err;

    int n_pass  = 0;
    int n_total = 0;

    csa64_op_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .in_cin   (in_cin),
        .ope1     (ope1),
        .ope2     (ope2),
        .add_sub  (add_sub),
        .Cin      (Cin),
        .start    (start),
        .sum      (sum),
        .cout     (cout),
        .complete (complete),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_zero (out_zero),
        .out_err  (out_err)
    );

    always #5 clock = ~clock;

    // Result fields: sum, cout, ovf, zero, err
    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        e;
    } res_t;

    // Reference arithmetic. Carry comes from an unsigned 65-bit sum.
    // Overflow means the exact signed result does not fit in 64 bits.
    function automatic res_t ref_op(input logic [63:0] a, input logic [63:0] b,
                                    input logic sub, input logic cin);
        res_t              r;
        logic [64:0]       u;
        logic signed [65:0] sa, sb, sx;
        sa = $signed({{2{a[63]}}, a});
        sb = $signed({{2{b[63]}}, b});
        if (sub) begin
            u  = {1'b0, a} + {1'b0, ~b} + 65'd1;
            sx = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            sx = sa + sb + $signed({65'd0, cin});
        end
        r.s = u[63:0];
        r.c = u[64];
        r.v = (sx > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (sx < -66'sh0_8000_0000_0000_0000);
        r.z = (u[63:0] == 64'd0);
        r.e = 1'b0;
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One full operation: request, launch/wait with the emulated adder,
    // optional DONE hold with a rejected request, then release.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic cin,
                          input int n_wait, input bit stale, input bit no_complete,
                          input int hold, input bit poke, input string tag);
        res_t exp_r;
        res_t got_r;
        res_t cmp_r;
        res_t held_r;
        int   exp_edge;
        int   first;
        bit   busy_ok;
        bit   hold_ok;
        exp_r    = no_complete ? res_t'(0) : ref_op(a, b, sub, cin);
        exp_r.e  = no_complete;
        exp_edge = no_complete ? 1 + TIMEOUT : 2 + n_wait;

        @(negedge clock);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
        complete = stale;
        sum = rnd64(); cout = $urandom_range(0, 1);
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL %s accept_ready: in_ready=%b required 1", tag, in_ready);
        else n_pass++;

        @(posedge clock); #1;
        // Scramble the request bus so late re-latching would be visible.
        in_valid = 1'b0; in_a = rnd64(); in_b = rnd64();
        in_sub = $urandom_range(0, 1); in_cin = $urandom_range(0, 1);

        busy_ok = 1'b1;
        first   = -1;
        for (int k = 0; k <= 400 && first < 0; k++) begin
            if (k > 0) begin
                @(posedge clock); #1;
            end
            if (out_valid === 1'b1) begin
                first = k;
            end else begin
                if (start !== 1'b1 || in_ready !== 1'b0 || ope1 !== a || ope2 !== b ||
                    add_sub !== sub || Cin !== (sub ? 1'b0 : cin)) begin
                    if (busy_ok)
                        $display("FAIL %s busy k=%0d: start=%b in_ready=%b ope1=%h ope2=%h add_sub=%b Cin=%b required 1 0 %h %h %b %b",
                                 tag, k, start, in_ready, ope1, ope2, add_sub, Cin, a, b, sub, sub ? 1'b0 : cin);
                    busy_ok = 1'b0;
                end
                // Value of complete seen at edge k+1.
                complete = stale || (!no_complete && (k + 1) >= 2 + n_wait);
                if (complete) begin
                    cmp_r = ref_op(ope1, ope2, add_sub, Cin);
                    sum = cmp_r.s; cout = cmp_r.c;
                end else begin
                    sum = rnd64(); cout = $urandom_range(0, 1);
                end
            end
        end
        n_total++;
        if (!busy_ok) $display("FAIL %s busy_phase: see line above, required held operands", tag);
        else n_pass++;
        n_total++;
        if (first !== exp_edge)
            $display("FAIL %s latency: out_valid after %0d edges required %0d", tag, first, exp_edge);
        else n_pass++;

        complete = 1'b0; sum = rnd64(); cout = $urandom_range(0, 1);
        got_r = '{out_sum, out_cout, out_ovf, out_zero, out_err};
        n_total++;
        if (got_r !== exp_r)
            $display("FAIL %s result: sum=%h c=%b v=%b z=%b e=%b required sum=%h c=%b v=%b z=%b e=%b",
                     tag, got_r.s, got_r.c, got_r.v, got_r.z, got_r.e,
                     exp_r.s, exp_r.c, exp_r.v, exp_r.z, exp_r.e);
        else n_pass++;

        // DONE hold: outputs stable, new request refused.
        held_r  = got_r;
        hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            if (poke) begin
                in_valid = 1'b1; in_a = rnd64(); in_b = rnd64();
                in_sub = $urandom_range(0, 1); in_cin = $urandom_range(0, 1);
            end
            @(posedge clock); #1;
            if ('{out_sum, out_cout, out_ovf, out_zero, out_err} !== held_r ||
                out_valid !== 1'b1 || in_ready !== 1'b0 || start !== 1'b0 ||
                ope1 !== a || ope2 !== b)
                hold_ok = 1'b0;
        end
        n_total++;
        if (!hold_ok || out_valid !== 1'b1 || start !== 1'b0)
            $display("FAIL %s done_hold: stable=%b out_valid=%b start=%b required 1 1 0",
                     tag, hold_ok, out_valid, start);
        else n_pass++;

        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_err !== 1'b0)
            $display("FAIL %s release: out_valid=%b in_ready=%b out_err=%b required 0 1 0",
                     tag, out_valid, in_ready, out_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        sum = '0; cout = 1'b0; complete = 1'b0; out_ready = 1'b0;
        #17;
        n_total++;
        if ({in_ready, start, out_valid} !== 3'b100)
            $display("FAIL reset_ctrl: in_ready/start/out_valid=%b required 100", {in_ready, start, out_valid});
        else n_pass++;
        n_total++;
        if ({ope1, ope2, add_sub, Cin, out_sum, out_cout, out_ovf, out_zero, out_err} !== '0)
            $display("FAIL reset_data: ope1=%h ope2=%h out_sum=%h flags=%b required all 0",
                     ope1, ope2, out_sum, {add_sub, Cin, out_cout, out_ovf, out_zero, out_err});
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clock);
        in_valid = 1'b1; in_a = rnd64(); in_b = rnd64(); in_sub = 1'b0; in_cin = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); @(posedge clock); #3;   // now inside WAIT
        n_total++;
        if (start !== 1'b1)
            $display("FAIL midwait_start: start=%b required 1", start);
        else n_pass++;
        reset = 1'b1;
        #1;                                        // no clock edge in between
        n_total++;
        if ({start, out_valid, in_ready} !== 3'b001 || ope1 !== '0)
            $display("FAIL midwait_reset: start/out_valid/in_ready=%b ope1=%h required 001 0",
                     {start, out_valid, in_ready}, ope1);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        // Next operation must start clean.
        run_op(64'd10, 64'd20, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_directed();
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 0, 1'b0, "add_ovf");
        run_op(64'd5, 64'd5, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1, 1'b0, "sub_zero");
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 0, 1'b0, "sub_ovf");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, "add_neg");
    endtask

    task automatic test_stale_complete();
        run_op(64'd123, 64'd456, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0, "stale_complete");
    endtask

    task automatic test_timeout();
        run_op(rnd64(), rnd64(), 1'b0, 1'b1, 0, 1'b0, 1'b1, 2, 1'b0, "timeout");
    endtask

    task automatic test_back_to_back();
        run_op(rnd64(), rnd64(), 1'b1, 1'b0, 2, 1'b0, 1'b0, 10, 1'b1, "hold_poke");
        run_op(rnd64(), rnd64(), 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, "second_op");
    endtask

    task automatic test_random();
        logic [63:0] corners [0:4];
        logic [63:0] a, b;
        bit          st;
        corners[0] = 64'd0;
        corners[1] = 64'h7FFF_FFFF_FFFF_FFFF;
        corners[2] = 64'h8000_0000_0000_0000;
        corners[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        corners[4] = 64'd1;
        for (int i = 0; i < 24; i++) begin
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : rnd64();
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : rnd64();
            st = ($urandom_range(0, 5) == 0);
            run_op(a, b, $urandom_range(0, 1), $urandom_range(0, 1),
                   st ? 0 : $urandom_range(0, 6), st, 1'b0,
                   $urandom_range(0, 3), $urandom_range(0, 1), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_directed();
        test_stale_complete();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global bound so a stuck handshake can never hang the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
